// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the round-robin uart_tx arbiter.
// The optional watchdog is compiled in with UART_ARB_TIMEOUT_EN.
package uart_pkg;

   localparam int UART_DW                = 8;
   localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      BUSY  = ST_BUSY,
      ACK   = ST_ACK
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority selector: the first set request after the
// pointer (wrapping modulo N) wins; returns it one-hot and as an index.
module rr_arbiter #(
   parameter int N = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_valid
);

   logic [PW-1:0] cand;

   // Scan from the farthest offset down so the nearest requester after the pointer wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      cand    = '0;
      for (int i = N; i >= 1; i--) begin
         cand = PW'((int'(i_ptr) + i) % N);
         if (i_req[cand]) begin
            o_grant       = '0;
            o_grant[cand] = 1'b1;
            o_idx         = cand;
            o_valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N requesters: round-robin pick, latch byte, start, wait done, ack.
// Define UART_ARB_TIMEOUT_EN to add a BUSY watchdog and the sticky o_timeout flag.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N              = 2,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         i_req,
   input  logic [UART_DW*N-1:0] i_data,
   output logic [N-1:0]         o_grant,
   output logic [N-1:0]         o_ack,
   output logic                 o_busy,
   output logic                 o_tx_start,
   output logic [UART_DW-1:0]   o_tx_data,
   input  logic                 i_tx_done
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                 o_timeout
`endif
);

   localparam int PW = $clog2(N);

   if (N < 2 || N > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("uart_tx_arbiter: N must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   state_t               state_q;
   logic [PW-1:0]        ptr_q;
   logic [N-1:0]         grant_q;
   logic [N-1:0]         ack_q;
   logic                 busy_q;
   logic                 start_q;
   logic [UART_DW-1:0]   data_q;

   logic [N-1:0]         winGrant;
   logic [PW-1:0]        winIdx;
   logic                 winValid;
   logic [UART_DW-1:0]   winData;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]        tmo_q;
   logic                 timeout_q;
`endif

   rr_arbiter #(.N(N)) u_rr (
      .i_req   (i_req),
      .i_ptr   (ptr_q),
      .o_grant (winGrant),
      .o_idx   (winIdx),
      .o_valid (winValid)
   );

   always_comb begin
      winData = '0;
      for (int k = 0; k < N; k++) begin
         if (winGrant[k]) winData = i_data[k*UART_DW +: UART_DW];
      end
   end

   // Done pulses outside BUSY fall through untouched, so they are ignored by construction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ptr_q     <= PW'(N - 1);
         grant_q   <= '0;
         ack_q     <= '0;
         busy_q    <= 1'b0;
         start_q   <= 1'b0;
         data_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         tmo_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         ack_q   <= '0;
         case (state_q)
            IDLE: begin
               if (winValid) begin
                  grant_q <= winGrant;
                  data_q  <= winData;
                  ptr_q   <= winIdx;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= START;
               end
            end
            START: begin
               state_q <= BUSY;
`ifdef UART_ARB_TIMEOUT_EN
               tmo_q   <= '0;
`endif
            end
            BUSY: begin
               if (i_tx_done) begin
                  ack_q   <= grant_q;
                  state_q <= ACK;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  ack_q     <= grant_q;
                  timeout_q <= 1'b1;
                  state_q   <= ACK;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            ACK: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_grant    = grant_q;
   assign o_ack      = ack_q;
   assign o_busy     = busy_q;
   assign o_tx_start = start_q;
   assign o_tx_data  = data_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign o_timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with N=4; the bench plays the uart_tx.
// With UART_ARB_TIMEOUT_EN defined it also exercises the watchdog at TIMEOUT_CYCLES=20.
module tb_uart_tx_arbiter;

   localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int TMO = 20;
`else
   localparam int TMO = 65535;
`endif

   typedef struct {
      int       idx;
      logic [7:0] data;
   } sbEntry_t;

   logic         clk;
   logic         reset;
   logic [N-1:0] iReq;
   logic [8*N-1:0] iData;
   logic [N-1:0] oGrant;
   logic [N-1:0] oAck;
   logic         oBusy;
   logic         oTxStart;
   logic [7:0]   oTxData;
   logic         iTxDone;
`ifdef UART_ARB_TIMEOUT_EN
   logic         oTimeout;
`endif

   int checks = 0;
   int errors = 0;
   sbEntry_t sbQ[$];
   int         curIdx;
   logic [N-1:0] curGrant;
   logic [7:0] curData;

   uart_tx_arbiter #(.N(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (iReq),
      .i_data     (iData),
      .o_grant    (oGrant),
      .o_ack      (oAck),
      .o_busy     (oBusy),
      .o_tx_start (oTxStart),
      .o_tx_data  (oTxData),
      .i_tx_done  (iTxDone)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .o_timeout  (oTimeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic req, input logic [7:0] data);
      iReq[idx] = req;
      iData[idx*8 +: 8] = data;
   endtask

   task automatic expectServe(input int idx, input logic [7:0] data);
      sbEntry_t e;
      e.idx  = idx;
      e.data = data;
      sbQ.push_back(e);
   endtask

   // Waits (bounded) for the start pulse, then compares grant/byte with the scoreboard head.
   task automatic waitStart();
      int n;
      sbEntry_t e;
      n = 0;
      while (oTxStart !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checkOutput("start_seen", 32'(oTxStart), 32'd1);
         return;
      end
      if (sbQ.size() == 0) begin
         checkOutput("sb_nonempty", 32'(sbQ.size()), 32'd1);
         return;
      end
      e = sbQ.pop_front();
      curIdx   = e.idx;
      curGrant = '0;
      curGrant[e.idx] = 1'b1;
      curData  = e.data;
      checkOutput("start_grant", 32'(oGrant), 32'(curGrant));
      checkOutput("start_data", 32'(oTxData), 32'(curData));
      checkOutput("start_busy", 32'(oBusy), 32'd1);
      checkOutput("start_ack", 32'(oAck), 32'd0);
   endtask

   // Plays uart_tx: delay BUSY cycles, one done pulse, then checks the ack cycle.
   task automatic finishTransfer(input int delay);
      repeat (delay) begin
         @(negedge clk);
         checkOutput("busy_start_low", 32'(oTxStart), 32'd0);
         checkOutput("busy_data_hold", 32'(oTxData), 32'(curData));
         checkOutput("busy_no_ack", 32'(oAck), 32'd0);
      end
      iTxDone = 1'b1;
      @(negedge clk);
      iTxDone = 1'b0;
      checkOutput("ack_vec", 32'(oAck), 32'(curGrant));
      checkOutput("ack_grant", 32'(oGrant), 32'(curGrant));
   endtask

   initial begin
      reset   = 1'b0;
      iReq    = '0;
      iData   = '0;
      iTxDone = 1'b0;
      curIdx  = 0;
      curGrant = '0;
      curData = '0;

      @(negedge clk);
      checkOutput("rst_grant", 32'(oGrant), 32'd0);
      checkOutput("rst_ack", 32'(oAck), 32'd0);
      checkOutput("rst_busy", 32'(oBusy), 32'd0);
      checkOutput("rst_start", 32'(oTxStart), 32'd0);
      checkOutput("rst_data", 32'(oTxData), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] single request");
      applyStimulus(0, 1'b1, 8'h55);
      expectServe(0, 8'h55);
      waitStart();
      finishTransfer(9);
      applyStimulus(0, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("single_ack_clear", 32'(oAck), 32'd0);
      checkOutput("single_idle_busy", 32'(oBusy), 32'd0);
      checkOutput("single_grant_clear", 32'(oGrant), 32'd0);

      $display("[TB] spurious done");
      iTxDone = 1'b1;
      @(negedge clk);
      iTxDone = 1'b0;
      @(negedge clk);
      checkOutput("idle_done_busy", 32'(oBusy), 32'd0);
      checkOutput("idle_done_ack", 32'(oAck), 32'd0);
      checkOutput("idle_done_start", 32'(oTxStart), 32'd0);
      applyStimulus(0, 1'b1, 8'h3C);
      expectServe(0, 8'h3C);
      waitStart();
      iTxDone = 1'b1;
      @(negedge clk);
      iTxDone = 1'b0;
      checkOutput("start_done_busy", 32'(oBusy), 32'd1);
      checkOutput("start_done_ack", 32'(oAck), 32'd0);
      finishTransfer(5);
      applyStimulus(0, 1'b0, 8'h00);

      $display("[TB] withdrawal");
      @(negedge clk);
      applyStimulus(2, 1'b1, 8'h22);
      expectServe(2, 8'h22);
      waitStart();
      applyStimulus(1, 1'b1, 8'h11);
      @(negedge clk);
      applyStimulus(1, 1'b0, 8'h00);
      finishTransfer(4);
      applyStimulus(2, 1'b0, 8'h00);
      repeat (4) begin
         @(negedge clk);
         checkOutput("withdraw_idle_busy", 32'(oBusy), 32'd0);
         checkOutput("withdraw_no_start", 32'(oTxStart), 32'd0);
      end
      applyStimulus(1, 1'b1, 8'h77);
      expectServe(1, 8'h77);
      waitStart();
      applyStimulus(1, 1'b0, 8'h00);
      finishTransfer(4);

      $display("[TB] reset in busy");
      @(negedge clk);
      applyStimulus(0, 1'b1, 8'h99);
      expectServe(0, 8'h99);
      waitStart();
      @(negedge clk);
      #2 reset = 1'b0;
      applyStimulus(0, 1'b0, 8'h00);
      #1;
      checkOutput("midrst_grant", 32'(oGrant), 32'd0);
      checkOutput("midrst_busy", 32'(oBusy), 32'd0);
      checkOutput("midrst_data", 32'(oTxData), 32'd0);
      checkOutput("midrst_ack", 32'(oAck), 32'd0);
      @(negedge clk);
      checkOutput("midrst_ack_held", 32'(oAck), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] contention");
      for (int k = 0; k < N; k++) begin
         applyStimulus(k, 1'b1, 8'hA0 + 8'(k));
         expectServe(k, 8'hA0 + 8'(k));
      end
      expectServe(0, 8'hB0);
      for (int t = 0; t < 5; t++) begin
         waitStart();
         finishTransfer(3);
         if (t == 0) applyStimulus(0, 1'b1, 8'hB0);
         else applyStimulus(curIdx, 1'b0, 8'h00);
      end
      @(negedge clk);
      @(negedge clk);
      checkOutput("contention_done_busy", 32'(oBusy), 32'd0);
      checkOutput("contention_sb_empty", 32'(sbQ.size()), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
      $display("[TB] watchdog");
      checkOutput("tmo_initial", 32'(oTimeout), 32'd0);
      applyStimulus(1, 1'b1, 8'h5A);
      expectServe(1, 8'h5A);
      waitStart();
      begin
         int n;
         n = 0;
         while (oAck === '0 && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput("tmo_ack_cycle", 32'(n), 32'd21);
         checkOutput("tmo_ack_vec", 32'(oAck), 32'(curGrant));
         checkOutput("tmo_flag", 32'(oTimeout), 32'd1);
      end
      applyStimulus(1, 1'b0, 8'h00);
      applyStimulus(2, 1'b1, 8'h6B);
      expectServe(2, 8'h6B);
      waitStart();
      finishTransfer(3);
      applyStimulus(2, 1'b0, 8'h00);
      checkOutput("tmo_sticky", 32'(oTimeout), 32'd1);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter between N independent requesters using round-robin arbitration.
- Sequences the transmitter: latches the winning byte, pulses start, waits for done, acknowledges the requester.
- Sits between the wishbone peripherals (wb_uart, debug/log sources) and the single uart_tx instance.

Parameters:
- N, 2, number of requesters (legal range 2..8).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles (used only when UART_ARB_TIMEOUT_EN is defined).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- i_req  in  N  per-requester request level.
- i_data  in  8*N  byte of requester k on bits [8k+7:8k].
- o_grant  out  N  one-hot; high from the start cycle through the done cycle.
- o_ack  out  N  one-cycle completion pulse to the served requester.
- o_busy  out  1  high in any state other than IDLE.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_tx_data  out  8  latched byte for uart_tx; stable from the start pulse until done.
- i_tx_done  in  1  one-cycle completion pulse from uart_tx.
- o_timeout  out  1  sticky watchdog flag; present only with UART_ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, async) sets every output to 0, state=IDLE, rr pointer=N-1 (requester 0 wins first).
- States: IDLE, START, BUSY, ACK. All outputs are registered.
- IDLE:
  - If any i_req is set, pick the first set bit searching from pointer+1 mod N, wrapping.
  - Latch the winner's i_data into o_tx_data, set o_grant, update pointer to the winner, go to START.
  - If no request, stay in IDLE.
- START: o_tx_start=1 for exactly this cycle, then go to BUSY. An i_tx_done arriving here is ignored.
- BUSY: hold o_grant and o_tx_data. On i_tx_done=1, go to ACK.
- ACK:
  - o_ack[winner]=1 for one cycle, o_grant clears at the end of the cycle, then go to IDLE.
- Latency: request sampled at edge e; start high in cycle e+1; ack high one cycle after done is sampled. Minimum per-byte overhead is 3 cycles beyond the uart_tx duration.
- Requester handshake:
  - Hold i_req high and i_data stable until o_ack.
  - Update i_req and i_data on the edge that ends the ack cycle.
  - Streaming: keep i_req high with the next byte.
  - Dropping i_req before a grant withdraws the request.
  - Dropping i_req after a grant has no effect: the latched byte still completes and is acked.
- Fairness: a requester with i_req held continuously is served at least once every N transfers.
- i_tx_done in IDLE, START or ACK is ignored. Multiple done pulses in BUSY: only the first counts.
- Reset mid-transfer aborts immediately: no ack is issued and the pointer returns to N-1. The uart_tx instance must share the same reset.
- Pointer arithmetic is modulo N for non-power-of-2 N; pointer width is clog2(N).

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle.
  - At TIMEOUT_CYCLES without done: go to ACK, issue o_ack as normal, set o_timeout=1.
  - o_timeout stays sticky until reset.
- Not defined: no counter and no o_timeout port; BUSY waits indefinitely for i_tx_done.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=0, START=1, BUSY=2, ACK=3);
  - byte width constant UART_DW=8;
  - default TIMEOUT_CYCLES.
- One sub-module, rr_arbiter:
  - combinational rotate-priority select from i_req and pointer;
  - outputs a one-hot winner and its index.
  - The pointer register stays in uart_tx_arbiter.

Test Plan:
- Single request: i_req=0b01, data0=0x55; model done 10 cycles after start -> start pulses once, o_tx_data=0x55, o_ack=0b01 one cycle after done, o_busy low afterwards.
- Contention, N=4: all i_req high, distinct bytes 0xA0..0xA3 streamed -> grant order 0,1,2,3,0 and tx bytes in the same order.
- Withdrawal: req1 raised then dropped before IDLE samples it while req2 is high -> only requester 2 is served; req1 dropped after grant still receives ack.
- Spurious done: pulse i_tx_done in IDLE and in the START cycle -> no state change and no ack; a later real done completes normally.
- Async reset asserted in BUSY -> all outputs 0 immediately with no ack; the next request from requester 0 wins first.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, no done given -> ack at cycle 20 of BUSY, o_timeout=1 and sticky, next request still served.
